// File: rtl/rv32_data_memory_be.sv
// Byte-enabled single-clock data memory: one write and one read port per cycle,
// registered read result with 1 or 2 cycles of latency and optional write-first bypass.
module rv32_data_memory_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_coll
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (!(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_lat
            $error("rv32_data_memory_be: RD_LAT must be 1 or 2");
        end
        if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
            $error("rv32_data_memory_be: DATA_W must be a non-zero multiple of 8");
        end
    endgenerate

    // Requests have no ready: every rd_en/wr_en seen on a rising edge is taken.
    // rd_valid pulses for one cycle per accepted read, RD_LAT edges later, in order.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              hit;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        hit     = wr_en && (wr_addr == rd_addr);
        rd_word = mem[rd_addr];
        if ((BYPASS != 0) && hit) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Array is never cleared; writes are simply blocked while reset is held.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // The full result is resolved on the accepting edge, so a write on any later
    // edge cannot reach a read already in flight.
    logic              s1_valid;
    logic              s1_coll;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_coll  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            s1_coll  <= rd_en && hit;
            if (rd_en) s1_data <= rd_word;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid;
            logic              s2_coll;
            logic [DATA_W-1:0] s2_data;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_coll  <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_coll  <= s1_coll;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign rd_valid = s2_valid;
            assign rd_coll  = s2_coll;
            assign rd_data  = s2_data;
        end else begin : g_lat1
            assign rd_valid = s1_valid;
            assign rd_coll  = s1_coll;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_rv32_data_memory_be.sv
// Scoreboard bench: two instances (RD_LAT=1/BYPASS=1 and RD_LAT=2/BYPASS=0) share
// one stimulus stream; a word-level model predicts every read result.
module tb_rv32_data_memory_be;
    localparam int DW = 32;
    localparam int AW = 13;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic          rd_valid_a, rd_coll_a, rd_valid_b, rd_coll_b;
    logic [DW-1:0] rd_data_a, rd_data_b;

    always #5 clock = ~clock;

    rv32_data_memory_be #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_coll(rd_coll_a));

    rv32_data_memory_be #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_coll(rd_coll_b));

    int checks = 0;
    int errors = 0;

    // Expected entries are {coll, data}.
    logic [DW:0]   exp_qa[$];
    logic [DW:0]   exp_qb[$];
    logic [DW:0]   ea, eb;
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    logic [DW-1:0] model [0:31];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [3:0] be,
                                            input logic [DW-1:0] nw);
        logic [DW-1:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    // One cycle of stimulus; inputs change #1 after the rising edge.
    task automatic issue(input logic we, input logic [AW-1:0] wa, input logic [3:0] be,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        logic          coll;
        logic [DW-1:0] old;
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
        if (re) begin
            old  = model[ra[4:0]];
            coll = we && (wa == ra);
            exp_qa.push_back({coll, coll ? merge(old, be, wd) : old});
            exp_qb.push_back({coll, old});
        end
        if (we) model[wa[4:0]] = merge(model[wa[4:0]], be, wd);
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, '0, 4'h0, '0, 1'b0, '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (rd_valid_a !== 1'b0 || rd_coll_a !== 1'b0 || rd_data_a !== '0) begin
            errors++;
            $display("FAIL %s_a: valid=%b coll=%b data=%h, required all zero", tag,
                     rd_valid_a, rd_coll_a, rd_data_a);
        end
        checks++;
        if (rd_valid_b !== 1'b0 || rd_coll_b !== 1'b0 || rd_data_b !== '0) begin
            errors++;
            $display("FAIL %s_b: valid=%b coll=%b data=%h, required all zero", tag,
                     rd_valid_b, rd_coll_b, rd_data_b);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if (rd_valid_a) begin
                if (exp_qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_valid: data=%h coll=%b, required no valid",
                             rd_data_a, rd_coll_a);
                end else begin
                    ea = exp_qa.pop_front();
                    if ({rd_coll_a, rd_data_a} !== ea) begin
                        errors++;
                        $display("FAIL a_read: coll=%b data=%h, required coll=%b data=%h",
                                 rd_coll_a, rd_data_a, ea[DW], ea[DW-1:0]);
                    end
                    last_a = ea[DW-1:0];
                end
            end else if (rd_data_a !== last_a || rd_coll_a !== 1'b0) begin
                errors++;
                $display("FAIL a_hold: coll=%b data=%h, required coll=0 data=%h",
                         rd_coll_a, rd_data_a, last_a);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if (rd_valid_b) begin
                if (exp_qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_valid: data=%h coll=%b, required no valid",
                             rd_data_b, rd_coll_b);
                end else begin
                    eb = exp_qb.pop_front();
                    if ({rd_coll_b, rd_data_b} !== eb) begin
                        errors++;
                        $display("FAIL b_read: coll=%b data=%h, required coll=%b data=%h",
                                 rd_coll_b, rd_data_b, eb[DW], eb[DW-1:0]);
                    end
                    last_b = eb[DW-1:0];
                end
            end else if (rd_data_b !== last_b || rd_coll_b !== 1'b0) begin
                errors++;
                $display("FAIL b_hold: coll=%b data=%h, required coll=0 data=%h",
                         rd_coll_b, rd_data_b, last_b);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        #1;
        check_zero_outputs("reset_state");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Preload addresses 0..31 with addr*3 so every read has a known answer.
        for (int a = 0; a < 32; a++) issue(1'b1, AW'(a), 4'hF, DW'(a * 3), 1'b0, '0);

        // Back-to-back streaming reads 0..7.
        for (int a = 0; a < 8; a++) issue(1'b0, '0, 4'h0, '0, 1'b1, AW'(a));
        idle(3);

        // Byte merge on address 5.
        issue(1'b1, 13'd5, 4'hF, 32'hAABBCCDD, 1'b0, '0);
        issue(1'b1, 13'd5, 4'h5, 32'h11223344, 1'b0, '0);
        issue(1'b0, '0, 4'h0, '0, 1'b1, 13'd5);
        idle(3);

        // Same-cycle collision, partial enables, then zero enables.
        issue(1'b1, 13'd9, 4'hF, 32'h00000000, 1'b0, '0);
        issue(1'b1, 13'd9, 4'h3, 32'hFFFFFFFF, 1'b1, 13'd9);
        issue(1'b1, 13'd9, 4'h0, 32'h5A5A5A5A, 1'b1, 13'd9);
        idle(3);

        // Write on the edge after a read must not leak into it.
        issue(1'b1, 13'd3, 4'hF, 32'h12345678, 1'b0, '0);
        issue(1'b0, '0, 4'h0, '0, 1'b1, 13'd3);
        issue(1'b1, 13'd3, 4'hF, 32'hDEADBEEF, 1'b0, '0);
        issue(1'b0, '0, 4'h0, '0, 1'b1, 13'd3);
        idle(3);

        // Zero-enable write is a no-op.
        issue(1'b1, 13'd1, 4'hF, 32'h0000ABCD, 1'b0, '0);
        issue(1'b1, 13'd1, 4'h0, 32'hFFFFFFFF, 1'b0, '0);
        issue(1'b0, '0, 4'h0, '0, 1'b1, 13'd1);
        idle(3);

        // Randomized mix over a small address window to provoke collisions.
        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
        end
        idle(4);

        // Reset with reads in flight: both pending results are dropped.
        issue(1'b0, '0, 4'h0, '0, 1'b1, 13'd5);
        reset = 1'b1;
        #1;
        check_zero_outputs("reset_midflight");
        exp_qa.delete();
        exp_qb.delete();
        last_a = '0;
        last_b = '0;
        wr_en = 1'b1; wr_addr = 13'd5; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_addr = 13'd5;
        @(posedge clock);
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_zero_outputs("reset_held");
        reset = 1'b0;
        idle(4);

        // Contents survive reset and the write during reset was ignored.
        for (int a = 0; a < 16; a++) issue(1'b0, '0, 4'h0, '0, 1'b1, AW'(a));
        issue(1'b1, 13'd20, 4'hC, 32'hCAFE0000, 1'b1, 13'd20);

        for (int i = 0; i < 10 && (exp_qa.size() != 0 || exp_qb.size() != 0); i++) idle(1);
        checks++;
        if (exp_qa.size() != 0) begin
            errors++;
            $display("FAIL a_drain: %0d reads outstanding, required 0", exp_qa.size());
        end
        checks++;
        if (exp_qb.size() != 0) begin
            errors++;
            $display("FAIL b_drain: %0d reads outstanding, required 0", exp_qb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
